// File: rtl/pellet_renderer.sv
// pellet_renderer
// Pixel-side consumer of the 64-bit pellet occupancy map.
// Once per frame the map is snapshotted; the snapshot then answers the VGA
// pixel stream with a two-stage pipelined "pellet here" bit, while a small
// FSM walks the snapshot one bit per cycle to count remaining pellets and
// pulse level_clear on a nonzero-to-zero transition between completed scans.
//
// Ports:
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   pellet_arr    occupancy map, index = row*8 + col, 1 = pellet present
//   frame_start   one-cycle pulse after the last visible line
//   hcount/vcount current pixel coordinates
//   pix_valid     hcount/vcount describe a visible pixel
//   pellet_pix    pellet colour select for the pixel presented 2 cycles ago
//   pix_valid_out pix_valid delayed 2 cycles
//   pellets_left  pellet count of the latest completed scan (0..64)
//   level_clear   one-cycle pulse when the board became empty
module pellet_renderer #(
  parameter int CELL_PX   = 32,
  parameter int PELLET_PX = 8,
  parameter int MAZE_X0   = 192,
  parameter int MAZE_Y0   = 112
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] pellet_arr,
  input  logic        frame_start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        pix_valid,
  output logic        pellet_pix,
  output logic        pix_valid_out,
  output logic [6:0]  pellets_left,
  output logic        level_clear
);

  localparam int CELL_LG = $clog2(CELL_PX);
  localparam int WIN_LO  = (CELL_PX - PELLET_PX) / 2;
  localparam int WIN_HI  = (CELL_PX + PELLET_PX) / 2 - 1;
  localparam logic [CELL_LG-1:0] WIN_LO_C  = CELL_LG'(WIN_LO);
  localparam logic [CELL_LG-1:0] WIN_HI_C  = CELL_LG'(WIN_HI);
  localparam logic [10:0]        MAZE_W_C  = 11'(8 * CELL_PX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [0:63]        snap_r;
  logic [10:0]        dx_s;
  logic [10:0]        dy_s;
  logic               in_maze_s;
  logic [5:0]         cell_idx_s;
  logic               pel_bit_s;

  logic               valid_s1_r;
  logic               hit_s1_r;
  logic [CELL_LG-1:0] ox_s1_r;
  logic [CELL_LG-1:0] oy_s1_r;
  logic               pellet_pix_r;
  logic               pix_valid_out_r;

  state_t             state_r;
  logic [5:0]         idx_r;
  logic [6:0]         acc_r;
  logic [6:0]         pellets_left_r;
  logic               level_clear_r;
  logic               armed_r;

  // Maze-relative coordinates and cell lookup for the incoming pixel.
  always_comb begin
    dx_s       = {1'b0, hcount} - 11'(MAZE_X0);
    dy_s       = {1'b0, vcount} - 11'(MAZE_Y0);
    // Negative offsets wrap to large unsigned values, so one unsigned
    // compare per axis covers both bounds.
    in_maze_s  = (dx_s < MAZE_W_C) && (dy_s < MAZE_W_C);
    cell_idx_s = {dy_s[CELL_LG+2:CELL_LG], dx_s[CELL_LG+2:CELL_LG]};
    pel_bit_s  = snap_r[cell_idx_s];
  end

  // Frame snapshot of the occupancy map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= 64'd0;
    end else if (frame_start) begin
      snap_r <= pellet_arr;
    end
  end

  // Pixel pipeline: stage 1 locates the cell, stage 2 applies the pellet window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_r      <= 1'b0;
      hit_s1_r        <= 1'b0;
      ox_s1_r         <= '0;
      oy_s1_r         <= '0;
      pellet_pix_r    <= 1'b0;
      pix_valid_out_r <= 1'b0;
    end else begin
      valid_s1_r      <= pix_valid;
      hit_s1_r        <= in_maze_s & pel_bit_s;
      ox_s1_r         <= dx_s[CELL_LG-1:0];
      oy_s1_r         <= dy_s[CELL_LG-1:0];
      pix_valid_out_r <= valid_s1_r;
      pellet_pix_r    <= valid_s1_r & hit_s1_r &
                         (ox_s1_r >= WIN_LO_C) & (ox_s1_r <= WIN_HI_C) &
                         (oy_s1_r >= WIN_LO_C) & (oy_s1_r <= WIN_HI_C);
    end
  end

  // Pellet count FSM: one snapshot bit per cycle, result published in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= 6'd0;
      acc_r          <= 7'd0;
      pellets_left_r <= 7'd0;
      level_clear_r  <= 1'b0;
      armed_r        <= 1'b0;
    end else begin
      level_clear_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            idx_r   <= 6'd0;
            acc_r   <= 7'd0;
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (frame_start) begin
            // New snapshot arrives this edge: abandon the partial count.
            idx_r <= 6'd0;
            acc_r <= 7'd0;
          end else begin
            acc_r <= acc_r + {6'd0, snap_r[idx_r]};
            idx_r <= idx_r + 6'd1;
            if (idx_r == 6'd63) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          pellets_left_r <= acc_r;
          level_clear_r  <= (acc_r == 7'd0) && armed_r;
          // Only a nonzero completed scan arms the next empty-board pulse.
          armed_r        <= (acc_r != 7'd0);
          if (frame_start) begin
            idx_r   <= 6'd0;
            acc_r   <= 7'd0;
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign pellet_pix    = pellet_pix_r;
  assign pix_valid_out = pix_valid_out_r;
  assign pellets_left  = pellets_left_r;
  assign level_clear   = level_clear_r;

endmodule
